// File: rtl/mc_controller.sv
// Multicycle MIPS controller: Moore FSM that sequences datapath control for lw, sw, R-type, beq, addi and j.
// Optional bne support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alucontrol,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_q, state_d;
   logic       pcwrite, branch, branch_ne;
   logic       irwrite_s, regwrite_s, memwrite_s;
   logic [2:0] funct_alu;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      state_d    = S_FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      memwrite_s = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            alusrcb   = 2'b01;
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MC_CONTROLLER_BNE_EN
               OP_BNE:       state_d = S_BNEEX;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXECUTE: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BEQEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch     = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_s = 1'b1;
         end
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
`ifdef MC_CONTROLLER_BNE_EN
         S_BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch     = 1'b1;
            branch_ne  = 1'b1;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables are masked by reset so the async return to FETCH cannot pulse a write.
   assign pcen     = reset_n & (pcwrite | (branch & (branch_ne ? ~zero : zero)));
   assign irwrite  = reset_n & irwrite_s;
   assign regwrite = reset_n & regwrite_s;
   assign memwrite = reset_n & memwrite_s;
   assign state    = state_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the MIPS instruction format.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port op, input, 6 bits: instr[31:26] from the instruction register.
REQ-005 The block SHALL have port funct, input, 6 bits: instr[5:0] from the instruction register.
REQ-006 The block SHALL have port zero, input, 1 bit: ALU equality flag, high when srca == srcb.
REQ-007 The block SHALL have port alucontrol, output, 3 bits: add 010, sub 110, and 000, or 001, slt 111.
REQ-008 The block SHALL have 1-bit outputs pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg and alusrca.
REQ-009 The block SHALL have 2-bit outputs alusrcb (00 reg B, 01 const 4, 10 signimm, 11 signimm<<2) and pcsrc (00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 The block SHALL have port state, output, 4 bits: current FSM state, for debug.

Function
REQ-011 The block SHALL be a Moore FSM; every output except pcen SHALL depend only on the state. pcen = pcwrite | (branch & zero), or pcwrite | (branch & ~zero) in BNEEX.
REQ-012 State encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
REQ-013 FETCH SHALL drive: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00, irwrite=1, pcwrite=1. Next state: DECODE.
REQ-014 DECODE SHALL drive alusrca=0, alusrcb=11, add. Next state by op: 100011/101011 to MEMADR, 000000 to EXECUTE, 000100 to BEQEX, 001000 to ADDIEX, 000010 to JEX, any other value to FETCH (illegal op is a no-op).
REQ-015 MEMADR SHALL drive alusrca=1, alusrcb=10, add. Next state: MEMRD for lw, MEMWR for sw.
REQ-016 MEMRD SHALL drive iord=1 and go to MEMWB. MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1 and go to FETCH.
REQ-017 MEMWR SHALL drive iord=1, memwrite=1 and go to FETCH.
REQ-018 EXECUTE SHALL drive alusrca=1, alusrcb=00 and the funct-decoded op, then go to ALUWB. ALUWB SHALL drive regdst=1, memtoreg=0, regwrite=1 and go to FETCH.
REQ-019 The funct decode SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct SHALL give add (010), never X.
REQ-020 BEQEX SHALL drive alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 and go to FETCH.
REQ-021 ADDIEX SHALL drive alusrca=1, alusrcb=10, add and go to ADDIWB. ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1 and go to FETCH.
REQ-022 JEX SHALL drive pcsrc=10, pcwrite=1 and go to FETCH.
REQ-023 Any output not listed for a state SHALL be 0; alucontrol SHALL be 010 in any state that does not name an ALU op.
REQ-024 Unused state codes SHALL go to FETCH on the next edge.
REQ-025 Instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles (bne 3).

Reset
REQ-026 When reset_n is low, state SHALL go to FETCH immediately, without waiting for clk.
REQ-027 While reset_n is low, pcen, irwrite, regwrite and memwrite SHALL be forced to 0.
REQ-028 The first rising edge after reset_n goes high SHALL execute FETCH.
REQ-029 Reset asserted mid-instruction SHALL abort the instruction; no write enable SHALL pulse afterwards for that instruction.

Configuration
REQ-030 When macro MC_CONTROLLER_BNE_EN is defined, op 000101 in DECODE SHALL go to BNEEX. BNEEX SHALL match BEQEX except that pcen = ~zero.
REQ-031 When MC_CONTROLLER_BNE_EN is undefined, op 000101 SHALL be illegal (DECODE goes to FETCH), and state 12 SHALL be unused.

Verification
REQ-032 Release reset_n; op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-033 op=000000, funct=101010 -> alucontrol=111 in EXECUTE; regwrite=1, regdst=1 in ALUWB; 4 cycles.
REQ-034 op=000100 with zero=1 -> pcen=1 in BEQEX. Same with zero=0 -> pcen=0, and the next state is FETCH.
REQ-035 op=111111 -> DECODE goes to FETCH; no regwrite or memwrite pulse occurs.
REQ-036 Drop reset_n in MEMWR between clock edges -> state=0 and memwrite=0 at once, before the next clk edge.
REQ-037 With MC_CONTROLLER_BNE_EN defined, op=000101 and zero=0 -> state 12, pcen=1. Without the macro, op=000101 -> DECODE goes to FETCH.
